// File: rtl/spi_byte_master.sv
// spi_byte_master: single-byte SPI mode-0 master, MSB first.
// A rising edge on io_ctl runs one 8-bit exchange with the slave.
module spi_byte_master #(
   parameter int CLK_DIV = 2
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       io_ctl,
   input  logic [7:0] io_dataTxd,
   output logic [7:0] io_dataRxd,
   output logic       io_SCK,
   input  logic       io_MISO,
   output logic       io_MOSI,
   output logic       io_CSn
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        state_q;
   logic          ctl_q;
   logic [7:0]    tx_sh_q;
   logic [7:0]    rx_sh_q;
   logic [7:0]    rxd_q;
   logic [2:0]    bit_q;
   logic [DW-1:0] div_q;
   logic          sck_q;
   logic          csn_q;
   logic          mosi_q;

   logic start;
   logic half_end;

   assign start    = io_ctl & ~ctl_q;
   assign half_end = (div_q == DIV_LAST);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         ctl_q   <= 1'b0;
         tx_sh_q <= '0;
         rx_sh_q <= '0;
         rxd_q   <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sck_q   <= 1'b0;
         csn_q   <= 1'b1;
         mosi_q  <= 1'b0;
      end else begin
         // ctl_q tracks io_ctl in every state so mid-transfer edges are consumed
         ctl_q <= io_ctl;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  tx_sh_q <= io_dataTxd;
                  mosi_q  <= io_dataTxd[7];
                  csn_q   <= 1'b0;
                  bit_q   <= '0;
                  div_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (half_end) begin
                  div_q <= '0;
                  sck_q <= ~sck_q;
                  if (!sck_q) begin
                     rx_sh_q <= {rx_sh_q[6:0], io_MISO};
                  end else if (bit_q == 3'd7) begin
                     state_q <= IDLE;
                     rxd_q   <= rx_sh_q;
                     csn_q   <= 1'b1;
                     sck_q   <= 1'b0;
                     mosi_q  <= 1'b0;
                  end else begin
                     tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                     mosi_q  <= tx_sh_q[6];
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign io_dataRxd = rxd_q;
   assign io_SCK     = sck_q;
   assign io_MOSI    = mosi_q;
   assign io_CSn     = csn_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: scoreboard bench for spi_byte_master.
// Instances with CLK_DIV 2, 1 and 4 share clock, reset, data and MISO.
module tb_spi_byte_master;

   logic             CLK = 1'b0;
   logic             RST_n = 1'b0;
   logic [2:0]       ctl = '0;
   logic [7:0]       tx = '0;
   logic [2:0][7:0]  rxd;
   logic [2:0]       sck;
   logic [2:0]       mosi;
   logic [2:0]       csn;
   logic             miso;
   logic             miso_c = 1'b0;
   logic             slave_mode = 1'b0;
   logic [7:0]       slave_sh = '0;

   int n_checks = 0;
   int n_fail = 0;

   logic [15:0] sb0[$];
   logic [15:0] sb1[$];
   logic [15:0] sb2[$];

   logic        p_sck [3];
   logic        p_csn [3];
   logic        act [3];
   int          rises [3];
   int          low [3];
   int          gap [3];
   int          done_cnt [3];
   logic [7:0]  mo_acc [3];
   logic [7:0]  hold [3];
   logic [15:0] cur [3];

   always #5 CLK = ~CLK;

   assign miso = slave_mode ? slave_sh[7] : miso_c;

   always @(negedge csn[0]) slave_sh = 8'h5A;
   always @(negedge sck[0]) slave_sh = {slave_sh[6:0], 1'b0};

   spi_byte_master #(.CLK_DIV(2)) u_dut0 (
      .CLK(CLK), .RST_n(RST_n), .io_ctl(ctl[0]),
      .io_dataTxd(tx), .io_dataRxd(rxd[0]), .io_SCK(sck[0]),
      .io_MISO(miso), .io_MOSI(mosi[0]), .io_CSn(csn[0]));

   spi_byte_master #(.CLK_DIV(1)) u_dut1 (
      .CLK(CLK), .RST_n(RST_n), .io_ctl(ctl[1]),
      .io_dataTxd(tx), .io_dataRxd(rxd[1]), .io_SCK(sck[1]),
      .io_MISO(miso), .io_MOSI(mosi[1]), .io_CSn(csn[1]));

   spi_byte_master #(.CLK_DIV(4)) u_dut2 (
      .CLK(CLK), .RST_n(RST_n), .io_ctl(ctl[2]),
      .io_dataTxd(tx), .io_dataRxd(rxd[2]), .io_SCK(sck[2]),
      .io_MISO(miso), .io_MOSI(mosi[2]), .io_CSn(csn[2]));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int div_of(input int i);
      case (i)
         0: return 2;
         1: return 1;
         default: return 4;
      endcase
   endfunction

   task automatic push_exp(input int i, input logic [7:0] t,
                           input logic [7:0] r);
      case (i)
         0: sb0.push_back({t, r});
         1: sb1.push_back({t, r});
         default: sb2.push_back({t, r});
      endcase
   endtask

   task automatic mon_step(input int i);
      logic [15:0] e;
      logic        got;
      if (!RST_n) begin
         p_sck[i] = 1'b0;
         p_csn[i] = 1'b1;
         act[i]   = 1'b0;
         rises[i] = 0;
         low[i]   = 0;
         gap[i]   = 1;
      end else begin
         if (p_csn[i] && !csn[i]) begin
            got = 1'b0;
            e   = '0;
            case (i)
               0: if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
               1: if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
               default: if (sb2.size() > 0) begin e = sb2.pop_front(); got = 1'b1; end
            endcase
            check($sformatf("xfer_expected%0d", i), 32'(got), 1);
            check($sformatf("csn_gap%0d", i), 32'(gap[i] >= 1), 1);
            act[i]    = got;
            cur[i]    = e;
            rises[i]  = 0;
            low[i]    = 0;
            mo_acc[i] = '0;
            hold[i]   = rxd[i];
         end
         if (!csn[i]) begin
            low[i]++;
            gap[i] = 0;
            if (!p_sck[i] && sck[i]) begin
               rises[i]++;
               mo_acc[i] = {mo_acc[i][6:0], mosi[i]};
               check($sformatf("rxd_hold%0d", i), 32'(rxd[i]), 32'(hold[i]));
            end
         end else begin
            gap[i]++;
         end
         if (!p_csn[i] && csn[i] && act[i]) begin
            check($sformatf("mosi_bits%0d", i), 32'(mo_acc[i]), 32'(cur[i][15:8]));
            check($sformatf("sck_pulses%0d", i), rises[i], 8);
            check($sformatf("csn_low%0d", i), low[i], 16 * div_of(i));
            check($sformatf("rxd%0d", i), 32'(rxd[i]), 32'(cur[i][7:0]));
            check($sformatf("sck_idle%0d", i), 32'(sck[i]), 0);
            check($sformatf("mosi_idle%0d", i), 32'(mosi[i]), 0);
            done_cnt[i]++;
            act[i] = 1'b0;
         end
         p_sck[i] = sck[i];
         p_csn[i] = csn[i];
      end
   endtask

   always @(negedge CLK) begin
      for (int i = 0; i < 3; i++) mon_step(i);
   end

   task automatic wait_done(input int i, input int target);
      int n;
      n = 0;
      while (done_cnt[i] < target && n < 400) begin
         @(posedge CLK);
         n++;
      end
      check($sformatf("done_to%0d", i), 32'(done_cnt[i] >= target), 1);
   endtask

   task automatic wait_rises(input int r);
      int n;
      n = 0;
      while (rises[0] < r && n < 200) begin
         @(posedge CLK);
         n++;
      end
      check("rise_to", 32'(rises[0] >= r), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) done_cnt[i] = 0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_csn", 32'(csn[0]), 1);
      check("rst_sck", 32'(sck[0]), 0);
      check("rst_mosi", 32'(mosi[0]), 0);
      check("rst_rxd", 32'(rxd[0]), 0);
      RST_n = 1'b1;

      @(posedge CLK); #1;
      tx = 8'hAB; miso_c = 1'b1; ctl[0] = 1'b1;
      push_exp(0, 8'hAB, 8'hFF);
      wait_done(0, 1);
      repeat (40) @(posedge CLK);
      check("held_no_rerun", done_cnt[0], 1);

      #1 ctl[0] = 1'b0;
      @(posedge CLK); #1;
      tx = 8'hC3; miso_c = 1'b0; ctl[0] = 1'b1;
      push_exp(0, 8'hC3, 8'h00);
      repeat (6) @(posedge CLK);
      #1 tx = 8'h00; ctl[0] = 1'b0;
      @(posedge CLK);
      #1 ctl[0] = 1'b1;
      wait_done(0, 2);
      repeat (40) @(posedge CLK);
      check("mid_edge_no_rerun", done_cnt[0], 2);
      #1 ctl[0] = 1'b0;
      @(posedge CLK);
      #1 ctl[0] = 1'b1;
      push_exp(0, 8'h00, 8'h00);
      wait_done(0, 3);

      #1 ctl[0] = 1'b0;
      @(posedge CLK); #1;
      tx = 8'h81; miso_c = 1'b0; ctl[0] = 1'b1;
      push_exp(0, 8'h81, 8'h00);
      wait_done(0, 4);
      #1 ctl[0] = 1'b0;
      @(posedge CLK); #1;
      tx = 8'h7E; miso_c = 1'b1; ctl[0] = 1'b1;
      push_exp(0, 8'h7E, 8'hFF);
      wait_done(0, 5);

      #1 ctl[0] = 1'b0;
      @(posedge CLK); #1;
      tx = 8'h3C; ctl[0] = 1'b1;
      push_exp(0, 8'h3C, 8'hFF);
      repeat (2) @(posedge CLK);
      wait_rises(3);
      @(negedge CLK);
      #2 RST_n = 1'b0;
      #1;
      check("abort_csn", 32'(csn[0]), 1);
      check("abort_sck", 32'(sck[0]), 0);
      check("abort_mosi", 32'(mosi[0]), 0);
      check("abort_rxd", 32'(rxd[0]), 0);
      sb0.delete();
      ctl[0] = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST_n = 1'b1;
      repeat (40) @(posedge CLK);
      check("post_rst_idle", done_cnt[0], 5);
      check("post_rst_csn", 32'(csn[0]), 1);

      #1;
      slave_mode = 1'b1;
      check("rxd_pre", 32'(rxd[0]), 0);
      tx = 8'h99; ctl[0] = 1'b1;
      push_exp(0, 8'h99, 8'h5A);
      wait_done(0, 6);

      @(posedge CLK); #1;
      slave_mode = 1'b0; miso_c = 1'b1; tx = 8'hAB;
      ctl[1] = 1'b1; ctl[2] = 1'b1;
      push_exp(1, 8'hAB, 8'hFF);
      push_exp(2, 8'hAB, 8'hFF);
      wait_done(1, 1);
      wait_done(2, 1);
      repeat (40) @(posedge CLK);
      check("div1_single", done_cnt[1], 1);
      check("div4_single", done_cnt[2], 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
